// File: rtl/pic_fetch.sv
// pic_fetch: program counter and instruction fetch stage feeding decode, with a 2-level call stack.
// Define PIC_STACK_ERR_EN to track stack depth and raise a sticky stack_err on overflow/underflow.
module pic_fetch #(
  parameter int                                 PIC_INSTR_WIDTH        = 12,
  parameter int                                 L2_PIC_INSTR_MEM_DEPTH = 9,
  parameter logic [L2_PIC_INSTR_MEM_DEPTH-1:0] RESET_VECTOR           = 9'h1FF,
  parameter logic [PIC_INSTR_WIDTH-1:0]        NOP_WORD               = 12'h000
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              en,
  output logic [L2_PIC_INSTR_MEM_DEPTH-1:0] imem_addr,
  input  logic [PIC_INSTR_WIDTH-1:0]        imem_rdata,
  output logic [PIC_INSTR_WIDTH-1:0]        instruction,
  output logic [L2_PIC_INSTR_MEM_DEPTH-1:0] instr_pc,
  output logic                              instr_valid,
  input  logic                              goto_enable,
  input  logic [L2_PIC_INSTR_MEM_DEPTH-1:0] goto_addr,
  input  logic                              call_enable,
  input  logic [L2_PIC_INSTR_MEM_DEPTH-2:0] call_addr,
  input  logic                              ret_enable,
  input  logic                              skip_req,
  output logic                              stack_err
);

  localparam int AW = L2_PIC_INSTR_MEM_DEPTH;
  localparam int IW = PIC_INSTR_WIDTH;

  logic [AW-1:0] pc_q, pc_d;
  logic [AW-1:0] rdata_pc_q, rdata_pc_d;
  logic          rdata_vld_q, rdata_vld_d;
  logic [IW-1:0] instr_q, instr_d;
  logic [AW-1:0] instr_pc_q, instr_pc_d;
  logic          valid_q, valid_d;
  logic [AW-1:0] ex_pc_q, ex_pc_d;
  logic [AW-1:0] stack0_q, stack0_d;
  logic [AW-1:0] stack1_q, stack1_d;
  logic [1:0]    squash_cnt_q, squash_cnt_d;
  logic          redirect;
  logic          squash_now;

  assign redirect    = en & (ret_enable | call_enable | goto_enable | skip_req);
  assign imem_addr   = pc_q;
  assign instruction = instr_q;
  assign instr_pc    = instr_pc_q;
  assign instr_valid = valid_q & ~redirect;

  always_comb begin
    pc_d         = pc_q;
    rdata_pc_d   = rdata_pc_q;
    rdata_vld_d  = rdata_vld_q;
    instr_d      = instr_q;
    instr_pc_d   = instr_pc_q;
    valid_d      = valid_q;
    ex_pc_d      = ex_pc_q;
    stack0_d     = stack0_q;
    stack1_d     = stack1_q;
    squash_cnt_d = squash_cnt_q;
    squash_now   = 1'b0;
    if (en) begin
      if (ret_enable) begin
        pc_d     = stack0_q;
        stack0_d = stack1_q;
      end else if (call_enable) begin
        pc_d     = {1'b0, call_addr};
        stack1_d = stack0_q;
        stack0_d = ex_pc_q + AW'(1);
      end else if (goto_enable) begin
        pc_d = goto_addr;
      end else if (skip_req) begin
        pc_d = ex_pc_q + AW'(2);
      end else begin
        pc_d = pc_q + AW'(1);
      end
      rdata_pc_d  = pc_q;
      rdata_vld_d = 1'b1;
      // Count 2 means the word now on imem_rdata was fetched before the redirect.
      squash_now  = redirect | (squash_cnt_q == 2'd2) | ~rdata_vld_q;
      valid_d     = ~squash_now;
      instr_d     = squash_now ? NOP_WORD : imem_rdata;
      instr_pc_d  = rdata_pc_q;
      ex_pc_d     = instr_pc_q;
      if (redirect)
        squash_cnt_d = 2'd2;
      else if (squash_cnt_q != 2'd0)
        squash_cnt_d = squash_cnt_q - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q         <= RESET_VECTOR;
      rdata_pc_q   <= '0;
      rdata_vld_q  <= 1'b0;
      instr_q      <= NOP_WORD;
      instr_pc_q   <= '0;
      valid_q      <= 1'b0;
      ex_pc_q      <= '0;
      stack0_q     <= '0;
      stack1_q     <= '0;
      squash_cnt_q <= 2'd0;
    end else begin
      pc_q         <= pc_d;
      rdata_pc_q   <= rdata_pc_d;
      rdata_vld_q  <= rdata_vld_d;
      instr_q      <= instr_d;
      instr_pc_q   <= instr_pc_d;
      valid_q      <= valid_d;
      ex_pc_q      <= ex_pc_d;
      stack0_q     <= stack0_d;
      stack1_q     <= stack1_d;
      squash_cnt_q <= squash_cnt_d;
    end
  end

`ifdef PIC_STACK_ERR_EN
  logic [1:0] depth_q, depth_d;
  logic       stack_err_q, stack_err_d;
  logic       err_event;

  always_comb begin
    depth_d     = depth_q;
    stack_err_d = stack_err_q;
    err_event   = 1'b0;
    if (en) begin
      if (ret_enable) begin
        if (depth_q == 2'd0) err_event = 1'b1;
        else                 depth_d   = depth_q - 2'd1;
      end else if (call_enable) begin
        if (depth_q == 2'd2) err_event = 1'b1;
        else                 depth_d   = depth_q + 2'd1;
      end
    end
    if (err_event) stack_err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      depth_q     <= 2'd0;
      stack_err_q <= 1'b0;
    end else begin
      depth_q     <= depth_d;
      stack_err_q <= stack_err_d;
`ifdef SIMULATION
      if (err_event) $error("pic_fetch: stack overflow/underflow at ex_pc %h", ex_pc_q);
`endif
    end
  end

  assign stack_err = stack_err_q;
`else
  assign stack_err = 1'b0;
`endif

endmodule

// File: tb/tb_pic_fetch.sv
// Self-checking bench for pic_fetch: directed scenarios plus random stimulus against a
// behavioural fetch model (one tagged in-flight memory read, address-level stack).
module tb_pic_fetch;

  logic        clk = 1'b0;
  logic        rst, en;
  logic [8:0]  imem_addr;
  logic [11:0] imem_rdata;
  logic [11:0] instruction;
  logic [8:0]  instr_pc;
  logic        instr_valid;
  logic        goto_enable;
  logic [8:0]  goto_addr;
  logic        call_enable;
  logic [7:0]  call_addr;
  logic        ret_enable, skip_req, stack_err;

  int n_checks = 0;
  int n_pass   = 0;

  logic [11:0] mem [512];

`ifdef PIC_STACK_ERR_EN
  localparam logic ERR_ON = 1'b1;
`else
  localparam logic ERR_ON = 1'b0;
`endif

  // Reference model state
  logic [8:0]  m_pc, m_ent_addr, m_ipc, m_expc;
  logic        m_ent_live, m_ivalid, m_exvalid, m_err;
  logic [11:0] m_instr;
  logic [8:0]  m_stack [2];
  int          m_depth;

  pic_fetch dut (
    .clk(clk), .rst(rst), .en(en),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .instruction(instruction), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .goto_enable(goto_enable), .goto_addr(goto_addr),
    .call_enable(call_enable), .call_addr(call_addr),
    .ret_enable(ret_enable), .skip_req(skip_req),
    .stack_err(stack_err)
  );

  always #5 clk = ~clk;

  // Synchronous program memory, stalled together with the stage.
  always @(posedge clk) if (en) imem_rdata <= mem[imem_addr];

  function automatic logic exp_err();
`ifdef PIC_STACK_ERR_EN
    return m_err;
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_edge(input logic r_n, e, rt, cl, gt, sk,
                            input logic [8:0] ga, input logic [7:0] ca);
    logic       redir;
    logic [8:0] nxt;
    if (!r_n) begin
      m_pc = 9'h1FF; m_ent_addr = 9'h000; m_ent_live = 1'b0;
      m_ipc = 9'h000; m_ivalid = 1'b0; m_instr = 12'h000;
      m_expc = 9'h000; m_exvalid = 1'b0;
      m_stack[0] = 9'h000; m_stack[1] = 9'h000; m_depth = 0; m_err = 1'b0;
    end else if (e) begin
      redir = rt | cl | gt | sk;
      if (rt) begin
        nxt = m_stack[0];
        if (m_depth == 0) m_err = 1'b1; else m_depth = m_depth - 1;
        m_stack[0] = m_stack[1];
      end else if (cl) begin
        nxt = {1'b0, ca};
        if (m_depth == 2) m_err = 1'b1; else m_depth = m_depth + 1;
        m_stack[1] = m_stack[0];
        m_stack[0] = m_expc + 9'd1;
      end else if (gt) begin
        nxt = ga;
      end else if (sk) begin
        nxt = m_expc + 9'd2;
      end else begin
        nxt = m_pc + 9'd1;
      end
      m_expc     = m_ipc;
      m_exvalid  = m_ivalid & ~redir;
      m_ipc      = m_ent_addr;
      m_ivalid   = m_ent_live & ~redir;
      m_instr    = m_ivalid ? mem[m_ent_addr] : 12'h000;
      m_ent_addr = m_pc;
      m_ent_live = ~redir;
      m_pc       = nxt;
    end
  endtask

  // Drive one cycle from a negedge, update the model at the posedge, return at the next negedge.
  task automatic step(input logic r_n, e, rt, cl, gt, sk,
                      input logic [8:0] ga, input logic [7:0] ca);
    rst = r_n; en = e;
    ret_enable = rt; call_enable = cl; goto_enable = gt; skip_req = sk;
    goto_addr = ga; call_addr = ca;
    @(posedge clk);
    model_edge(r_n, e, rt, cl, gt, sk, ga, ca);
    @(negedge clk);
    ret_enable = 1'b0; call_enable = 1'b0; goto_enable = 1'b0; skip_req = 1'b0;
  endtask

  task automatic idle();
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 9'h000, 8'h00);
  endtask

  task automatic jump(input logic [8:0] a);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, a, 8'h00);
  endtask

  task automatic advance_to_ex(input logic [8:0] a);
    int k = 0;
    while (!(m_exvalid && m_expc == a) && k < 600) begin
      idle();
      k++;
    end
    n_checks++;
    if (k >= 600) $display("FAIL advance_to_ex: ex_pc %h not reached within %0d cycles", a, k);
    else n_pass++;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'b1, 1'(i == 0), 1'(i == 1), 1'(i == 2), 1'b1, 9'h055, 8'h66);
    n_checks++; if (instr_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", instr_valid); else n_pass++;
    n_checks++; if (imem_addr !== 9'h1FF) $display("FAIL reset_imem_addr: got %h want 1ff", imem_addr); else n_pass++;
    n_checks++; if (instruction !== 12'h000) $display("FAIL reset_instr: got %h want 000", instruction); else n_pass++;
    n_checks++; if (instr_pc !== 9'h000) $display("FAIL reset_instr_pc: got %h want 000", instr_pc); else n_pass++;
    n_checks++; if (stack_err !== 1'b0) $display("FAIL reset_stack_err: got %b want 0", stack_err); else n_pass++;
  endtask

  task automatic test_sequential();
    logic [8:0] seq [3];
    seq[0] = 9'h1FF; seq[1] = 9'h000; seq[2] = 9'h001;
    idle();
    n_checks++; if (instr_valid !== 1'b0) $display("FAIL seq_first_valid: got %b want 0", instr_valid); else n_pass++;
    n_checks++; if (imem_addr !== 9'h000) $display("FAIL seq_wrap_addr: got %h want 000", imem_addr); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      idle();
      n_checks++; if (instr_valid !== 1'b1) $display("FAIL seq_valid[%0d]: got %b want 1", i, instr_valid); else n_pass++;
      n_checks++; if (instr_pc !== seq[i]) $display("FAIL seq_pc[%0d]: got %h want %h", i, instr_pc, seq[i]); else n_pass++;
      n_checks++; if (instruction !== mem[seq[i]]) $display("FAIL seq_instr[%0d]: got %h want %h", i, instruction, mem[seq[i]]); else n_pass++;
    end
  endtask

  task automatic test_goto();
    advance_to_ex(9'h010);
    goto_enable = 1'b1; goto_addr = 9'h040; #1;
    n_checks++; if (instr_valid !== 1'b0) $display("FAIL goto_kill: got %b want 0", instr_valid); else n_pass++;
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 9'h040, 8'h00);
    for (int i = 0; i < 2; i++) begin
      n_checks++; if (instr_valid !== 1'b0 || instruction !== 12'h000)
        $display("FAIL goto_squash[%0d]: got valid=%b instr=%h want 0/000", i, instr_valid, instruction); else n_pass++;
      idle();
    end
    n_checks++; if (instr_valid !== 1'b1 || instr_pc !== 9'h040)
      $display("FAIL goto_target: got valid=%b pc=%h want 1/040", instr_valid, instr_pc); else n_pass++;
    n_checks++; if (instruction !== mem[9'h040]) $display("FAIL goto_word: got %h want %h", instruction, mem[9'h040]); else n_pass++;
    idle();
    n_checks++; if (instr_valid !== 1'b1 || instr_pc !== 9'h041)
      $display("FAIL goto_next: got valid=%b pc=%h want 1/041", instr_valid, instr_pc); else n_pass++;
  endtask

  task automatic test_call_ret();
    advance_to_ex(9'h020);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 9'h000, 8'h80);
    n_checks++; if (instr_valid !== 1'b0) $display("FAIL call_squash: got %b want 0", instr_valid); else n_pass++;
    idle(); idle();
    n_checks++; if (instr_valid !== 1'b1 || instr_pc !== 9'h080)
      $display("FAIL call_target: got valid=%b pc=%h want 1/080", instr_valid, instr_pc); else n_pass++;
    advance_to_ex(9'h083);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 9'h000, 8'h00);
    idle();
    n_checks++; if (instr_valid !== 1'b0) $display("FAIL ret_squash: got %b want 0", instr_valid); else n_pass++;
    idle();
    n_checks++; if (instr_valid !== 1'b1 || instr_pc !== 9'h021)
      $display("FAIL ret_target: got valid=%b pc=%h want 1/021", instr_valid, instr_pc); else n_pass++;
    n_checks++; if (stack_err !== 1'b0) $display("FAIL call_ret_err: got %b want 0", stack_err); else n_pass++;
  endtask

  task automatic test_nested_calls();
    logic [8:0] ret_from [3];
    logic [8:0] ret_to   [3];
    ret_from[0] = 9'h0C1; ret_from[1] = 9'h0A2; ret_from[2] = 9'h092;
    ret_to[0]   = 9'h0A1; ret_to[1]   = 9'h091; ret_to[2]   = 9'h091;
    jump(9'h00C);
    advance_to_ex(9'h010);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 9'h000, 8'h8F);
    advance_to_ex(9'h090);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 9'h000, 8'h9F);
    n_checks++; if (stack_err !== 1'b0) $display("FAIL nest_err_2nd: got %b want 0", stack_err); else n_pass++;
    advance_to_ex(9'h0A0);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 9'h000, 8'hC0);
    n_checks++; if (stack_err !== ERR_ON) $display("FAIL nest_err_3rd: got %b want %b", stack_err, ERR_ON); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      advance_to_ex(ret_from[i]);
      step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 9'h000, 8'h00);
      idle(); idle();
      n_checks++; if (instr_valid !== 1'b1 || instr_pc !== ret_to[i])
        $display("FAIL nest_ret[%0d]: got valid=%b pc=%h want 1/%h", i, instr_valid, instr_pc, ret_to[i]); else n_pass++;
    end
    n_checks++; if (stack_err !== ERR_ON) $display("FAIL nest_err_sticky: got %b want %b", stack_err, ERR_ON); else n_pass++;
  endtask

  task automatic test_skip();
    logic [8:0] from_pc [2];
    logic [8:0] to_pc   [2];
    from_pc[0] = 9'h030; to_pc[0] = 9'h032;
    from_pc[1] = 9'h1FF; to_pc[1] = 9'h001;
    for (int i = 0; i < 2; i++) begin
      jump(from_pc[i] - 9'd4);
      advance_to_ex(from_pc[i]);
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 9'h000, 8'h00);
      idle(); idle();
      n_checks++; if (instr_valid !== 1'b1 || instr_pc !== to_pc[i])
        $display("FAIL skip[%0d]: got valid=%b pc=%h want 1/%h", i, instr_valid, instr_pc, to_pc[i]); else n_pass++;
    end
  endtask

  task automatic test_stall_reset();
    jump(9'h100);
    idle();
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 9'h000, 8'h44);
      n_checks++; if (instr_valid !== 1'b0 || imem_addr !== 9'h101 || instr_pc !== m_ipc)
        $display("FAIL stall_hold[%0d]: got valid=%b addr=%h pc=%h want 0/101/%h", i, instr_valid, imem_addr, instr_pc, m_ipc); else n_pass++;
    end
    idle();
    n_checks++; if (instr_valid !== 1'b1 || instr_pc !== 9'h100)
      $display("FAIL stall_resume: got valid=%b pc=%h want 1/100", instr_valid, instr_pc); else n_pass++;
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 9'h000, 8'h33);
    n_checks++; if (instr_valid !== 1'b0 || imem_addr !== 9'h1FF || instr_pc !== 9'h000)
      $display("FAIL rst_over_call: got valid=%b addr=%h pc=%h want 0/1ff/000", instr_valid, imem_addr, instr_pc); else n_pass++;
    n_checks++; if (stack_err !== 1'b0) $display("FAIL rst_err_clear: got %b want 0", stack_err); else n_pass++;
    advance_to_ex(9'h002);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 9'h000, 8'h00);
    idle(); idle();
    n_checks++; if (instr_valid !== 1'b1 || instr_pc !== 9'h000)
      $display("FAIL rst_stack_clear: got valid=%b pc=%h want 1/000", instr_valid, instr_pc); else n_pass++;
    n_checks++; if (stack_err !== ERR_ON) $display("FAIL rst_underflow: got %b want %b", stack_err, ERR_ON); else n_pass++;
  endtask

  task automatic test_random();
    logic       r_n, e, rt, cl, gt, sk, ev;
    logic [8:0] ga;
    logic [7:0] ca;
    int         r;
    for (int i = 0; i < 400; i++) begin
      r_n = ($urandom_range(0, 49) != 0);
      e   = ($urandom_range(0, 5) != 0);
      r   = $urandom_range(0, 15);
      rt  = (r == 0) || (r == 4);
      cl  = (r == 1) || (r == 4);
      gt  = (r == 2) || (r == 4);
      sk  = (r == 3) || (r == 4);
      ga  = 9'($urandom);
      ca  = 8'($urandom);
      rst = r_n; en = e; ret_enable = rt; call_enable = cl; goto_enable = gt; skip_req = sk;
      goto_addr = ga; call_addr = ca;
      #1;
      ev = m_ivalid & ~(e & (rt | cl | gt | sk));
      n_checks++; if (instr_valid !== ev) $display("FAIL rnd_kill[%0d]: got %b want %b", i, instr_valid, ev); else n_pass++;
      step(r_n, e, rt, cl, gt, sk, ga, ca);
      n_checks++; if (instr_valid !== m_ivalid) $display("FAIL rnd_valid[%0d]: got %b want %b", i, instr_valid, m_ivalid); else n_pass++;
      n_checks++; if (instr_pc !== m_ipc) $display("FAIL rnd_pc[%0d]: got %h want %h", i, instr_pc, m_ipc); else n_pass++;
      n_checks++; if (instruction !== m_instr) $display("FAIL rnd_instr[%0d]: got %h want %h", i, instruction, m_instr); else n_pass++;
      n_checks++; if (imem_addr !== m_pc) $display("FAIL rnd_addr[%0d]: got %h want %h", i, imem_addr, m_pc); else n_pass++;
      n_checks++; if (stack_err !== exp_err()) $display("FAIL rnd_err[%0d]: got %b want %b", i, stack_err, exp_err()); else n_pass++;
    end
    rst = 1'b1; en = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 12'($urandom);
    rst = 1'b0; en = 1'b1;
    goto_enable = 1'b0; goto_addr = 9'h000; call_enable = 1'b0; call_addr = 8'h00;
    ret_enable = 1'b0; skip_req = 1'b0;
    model_edge(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 9'h000, 8'h00);
    @(negedge clk);
    test_reset();
    test_sequential();
    test_goto();
    test_call_ret();
    test_nested_calls();
    test_skip();
    test_stall_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
